// File: rtl/lt24_qsys_nios2_gen2_0_oci_dct_packer.sv
// OCI data-capture trace packer: packs 2-bit atoms LSB-first into 30-bit
// frames and hands them downstream through a one-entry holding register.
//
// Ports:
//   clk, reset                  rising-edge clock, sync active-high reset
//   atom_valid, atom[1:0]       incoming trace atom
//   flush                       pulse: emit the partial frame
//   frame_ready                 downstream accepts the held frame
//   frame_valid, frame_data,
//   frame_count                 holding register contents
//   dct_buffer, dct_count       live accumulator
//   overflow                    sticky: an atom was dropped
module lt24_qsys_nios2_gen2_0_oci_dct_packer #(
    parameter int MAX_ATOMS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        atom_valid,
    input  logic [1:0]  atom,
    input  logic        flush,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [29:0] frame_data,
    output logic [3:0]  frame_count,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        overflow
);

    typedef enum logic [1:0] {
        EMPTY,
        PART,
        FULL
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_ATOMS);

    state_t      state;
    logic        flush_pend;
    logic        out_free;
    logic        do_flush;
    logic [29:0] appended;
    logic [3:0]  cnt_tot;

    logic        nxt_pend;
    logic        nxt_ovf;
    logic [29:0] nxt_buf;
    logic [3:0]  nxt_cnt;
    logic        load;
    logic [29:0] ld_data;
    logic [3:0]  ld_cnt;

    always_comb begin
        if (dct_count == 4'd0)
            state = EMPTY;
        else if (dct_count == MAX_CNT)
            state = FULL;
        else
            state = PART;
    end

    assign out_free = !frame_valid || frame_ready;
    assign do_flush = flush || flush_pend;

    // Accumulator with the same-cycle atom placed at slot dct_count.
    // Only used when not FULL, so the shift stays inside 30 bits.
    always_comb begin
        appended = dct_buffer;
        if (atom_valid)
            appended = dct_buffer | ({28'd0, atom} << {dct_count, 1'b0});
    end

    assign cnt_tot = dct_count + {3'd0, atom_valid};

    always_comb begin
        nxt_buf  = dct_buffer;
        nxt_cnt  = dct_count;
        nxt_pend = flush_pend || flush;
        nxt_ovf  = overflow;
        load     = 1'b0;
        ld_data  = '0;
        ld_cnt   = '0;
        unique case (1'b1)
            (state == FULL) && out_free: begin
                load    = 1'b1;
                ld_data = dct_buffer;
                ld_cnt  = dct_count;
                if (atom_valid) begin
                    nxt_buf = {28'd0, atom};
                    nxt_cnt = 4'd1;
                end else begin
                    nxt_buf  = '0;
                    nxt_cnt  = 4'd0;
                    nxt_pend = 1'b0;
                end
            end
            (state == FULL) && !out_free: begin
                if (atom_valid)
                    nxt_ovf = 1'b1;
            end
            (state != FULL) && do_flush && out_free: begin
                // An empty flush is simply consumed with no frame.
                load     = (cnt_tot != 4'd0);
                ld_data  = appended;
                ld_cnt   = cnt_tot;
                nxt_buf  = '0;
                nxt_cnt  = 4'd0;
                nxt_pend = 1'b0;
            end
            default: begin
                if (atom_valid) begin
                    nxt_buf = appended;
                    nxt_cnt = cnt_tot;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer  <= '0;
            dct_count   <= '0;
            flush_pend  <= 1'b0;
            overflow    <= 1'b0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_count <= '0;
        end else begin
            dct_buffer <= nxt_buf;
            dct_count  <= nxt_cnt;
            flush_pend <= nxt_pend;
            overflow   <= nxt_ovf;
            if (load) begin
                frame_valid <= 1'b1;
                frame_data  <= ld_data;
                frame_count <= ld_cnt;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lt24_qsys_nios2_gen2_0_oci_dct_packer.sv
// Directed testbench for the OCI trace-atom packer.
// Scenario tasks run in sequence; each checks its own expectations.
module tb_lt24_qsys_nios2_gen2_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        flush;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    lt24_qsys_nios2_gen2_0_oci_dct_packer #(.MAX_ATOMS(15)) dut (
        .clk(clk),
        .reset(reset),
        .atom_valid(atom_valid),
        .atom(atom),
        .flush(flush),
        .frame_ready(frame_ready),
        .frame_valid(frame_valid),
        .frame_data(frame_data),
        .frame_count(frame_count),
        .dct_buffer(dct_buffer),
        .dct_count(dct_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        atom_valid = 1'b0;
        atom       = 2'd0;
        flush      = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        frame_ready = 1'b0;
        do_reset();
        checks++;
        if ({frame_valid, frame_data, frame_count, dct_buffer, dct_count,
             overflow} !== '0) begin
            failures++;
            $display("FAIL reset_state got fv=%b fd=%h fc=%0d buf=%h cnt=%0d ovf=%b want all zero",
                     frame_valid, frame_data, frame_count, dct_buffer,
                     dct_count, overflow);
        end
    endtask

    // Atom k sits at bits 2k+1:2k; codes 0,1,2,3 give bytes of 8'hE4,
    // and the last three atoms (0,1,2) give 6'h24 at the top.
    task automatic test_fill_emit();
        do_reset();
        frame_ready = 1'b1;
        for (int j = 0; j < 15; j++) begin
            atom_valid = 1'b1;
            atom       = 2'(j % 4);
            cyc();
        end
        idle();
        checks++;
        if (dct_count !== 4'd15 || dct_buffer !== 30'h24E4E4E4 ||
            frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL fill_acc got cnt=%0d buf=%h fv=%b want 15 24e4e4e4 0",
                     dct_count, dct_buffer, frame_valid);
        end
        cyc();
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd15 ||
            frame_data !== 30'h24E4E4E4 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL fill_frame got fv=%b fc=%0d fd=%h cnt=%0d want 1 15 24e4e4e4 0",
                     frame_valid, frame_count, frame_data, dct_count);
        end
        cyc();
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL fill_drain got fv=%b want 0", frame_valid);
        end
    endtask

    task automatic test_flush_atom();
        do_reset();
        frame_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            atom_valid = 1'b1;
            atom       = 2'd2;
            cyc();
        end
        atom  = 2'd1;
        flush = 1'b1;
        cyc();
        idle();
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd4 ||
            frame_data !== 30'h6A || dct_count !== 4'd0 ||
            dct_buffer !== 30'h0) begin
            failures++;
            $display("FAIL flush_atom got fv=%b fc=%0d fd=%h cnt=%0d buf=%h want 1 4 6a 0 0",
                     frame_valid, frame_count, frame_data, dct_count,
                     dct_buffer);
        end
        cyc();
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drain got fv=%b want 0", frame_valid);
        end
    endtask

    task automatic test_empty_flush();
        do_reset();
        frame_ready = 1'b1;
        flush = 1'b1;
        cyc();
        idle();
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_flush got fv=%b want 0", frame_valid);
        end
        atom_valid = 1'b1;
        atom       = 2'd3;
        cyc();
        idle();
        checks++;
        if (frame_valid !== 1'b0 || dct_count !== 4'd1 ||
            dct_buffer !== 30'h3) begin
            failures++;
            $display("FAIL empty_flush_atom got fv=%b cnt=%0d buf=%h want 0 1 3",
                     frame_valid, dct_count, dct_buffer);
        end
        cyc();
        checks++;
        if (frame_valid !== 1'b0 || dct_count !== 4'd1) begin
            failures++;
            $display("FAIL empty_flush_idle got fv=%b cnt=%0d want 0 1",
                     frame_valid, dct_count);
        end
    endtask

    // Atoms j=0..30 carry code j%4. Frame 1 is j=0..14, frame 2 is
    // j=15..29 (codes 3,0,1,2,... -> bytes 8'h93, top 6'h13), j=30 drops.
    task automatic test_backpressure();
        int stable_bad;
        stable_bad = 0;
        do_reset();
        frame_ready = 1'b0;
        for (int j = 0; j < 31; j++) begin
            atom_valid = 1'b1;
            atom       = 2'(j % 4);
            cyc();
            if (j == 14) begin
                checks++;
                if (dct_count !== 4'd15 || frame_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_first_full got cnt=%0d fv=%b want 15 0",
                             dct_count, frame_valid);
                end
            end
            if (j >= 15) begin
                checks++;
                if (frame_valid !== 1'b1 || frame_data !== 30'h24E4E4E4 ||
                    frame_count !== 4'd15) begin
                    failures++;
                    stable_bad++;
                    if (stable_bad < 4)
                        $display("FAIL bp_hold j=%0d got fv=%b fd=%h fc=%0d want 1 24e4e4e4 15",
                                 j, frame_valid, frame_data, frame_count);
                end
            end
            if (j == 29) begin
                checks++;
                if (dct_count !== 4'd15 || dct_buffer !== 30'h13939393 ||
                    overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_second_full got cnt=%0d buf=%h ovf=%b want 15 13939393 0",
                             dct_count, dct_buffer, overflow);
                end
            end
        end
        idle();
        checks++;
        if (overflow !== 1'b1 || dct_count !== 4'd15 ||
            dct_buffer !== 30'h13939393) begin
            failures++;
            $display("FAIL bp_overflow got ovf=%b cnt=%0d buf=%h want 1 15 13939393",
                     overflow, dct_count, dct_buffer);
        end
        frame_ready = 1'b1;
        cyc();
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h13939393 ||
            frame_count !== 4'd15 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL bp_frame2 got fv=%b fd=%h fc=%0d cnt=%0d want 1 13939393 15 0",
                     frame_valid, frame_data, frame_count, dct_count);
        end
        cyc();
        checks++;
        if (frame_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_drain got fv=%b ovf=%b want 0 1",
                     frame_valid, overflow);
        end
    endtask

    task automatic test_pending_flush();
        logic [1:0] codes [5];
        codes = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        frame_ready = 1'b1;
        atom_valid  = 1'b1;
        atom        = 2'd3;
        cyc();
        cyc();
        idle();
        flush = 1'b1;
        cyc();
        idle();
        frame_ready = 1'b0;
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'hF ||
            frame_count !== 4'd2) begin
            failures++;
            $display("FAIL pend_first got fv=%b fd=%h fc=%0d want 1 f 2",
                     frame_valid, frame_data, frame_count);
        end
        for (int j = 0; j < 5; j++) begin
            atom_valid = 1'b1;
            atom       = codes[j];
            cyc();
        end
        idle();
        flush = 1'b1;
        cyc();
        idle();
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'hF ||
            dct_count !== 4'd5 || dct_buffer !== 30'h139) begin
            failures++;
            $display("FAIL pend_blocked got fv=%b fd=%h cnt=%0d buf=%h want 1 f 5 139",
                     frame_valid, frame_data, dct_count, dct_buffer);
        end
        cyc();
        cyc();
        cyc();
        checks++;
        if (frame_data !== 30'hF || dct_count !== 4'd5) begin
            failures++;
            $display("FAIL pend_wait got fd=%h cnt=%0d want f 5",
                     frame_data, dct_count);
        end
        frame_ready = 1'b1;
        cyc();
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h139 ||
            frame_count !== 4'd5 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL pend_emit got fv=%b fd=%h fc=%0d cnt=%0d want 1 139 5 0",
                     frame_valid, frame_data, frame_count, dct_count);
        end
        cyc();
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_cleared got fv=%b want 0", frame_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        frame_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            atom_valid = 1'b1;
            atom       = 2'(j % 4);
            cyc();
        end
        idle();
        checks++;
        if (dct_count !== 4'd7) begin
            failures++;
            $display("FAIL mid_count got cnt=%0d want 7", dct_count);
        end
        flush = 1'b1;
        reset = 1'b1;
        cyc();
        flush = 1'b0;
        reset = 1'b0;
        checks++;
        if ({frame_valid, frame_data, frame_count, dct_buffer, dct_count,
             overflow} !== '0) begin
            failures++;
            $display("FAIL mid_reset got fv=%b fd=%h fc=%0d buf=%h cnt=%0d ovf=%b want all zero",
                     frame_valid, frame_data, frame_count, dct_buffer,
                     dct_count, overflow);
        end
        cyc();
        checks++;
        if (frame_valid !== 1'b0 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL mid_after got fv=%b cnt=%0d want 0 0",
                     frame_valid, dct_count);
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_ready = 1'b0;
        idle();
        #2;
        test_reset();
        test_fill_emit();
        test_flush_atom();
        test_empty_flush();
        test_backpressure();
        test_pending_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
